// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the sequenced ALU control decoder:
// control bit positions, FSM states and the shift-op mask.
package alu_ctrl_pkg;

   localparam int CTRL_W = 12;

   localparam int IDX_ADD      = 0;
   localparam int IDX_COMP     = 1;
   localparam int IDX_SLLV     = 2;
   localparam int IDX_SRLV     = 3;
   localparam int IDX_SRAV     = 4;
   localparam int IDX_AND      = 5;
   localparam int IDX_XOR      = 6;
   localparam int IDX_DIFF     = 7;
   localparam int IDX_COMPEQ   = 8;
   localparam int IDX_COMPNEQ  = 9;
   localparam int IDX_COMPLESS = 10;
   localparam int IDX_MEMADD   = 11;

   localparam logic [CTRL_W-1:0] SHIFT_MASK = 12'h01C;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

   function automatic logic is_shift(
      input logic [CTRL_W-1:0] c
   );
      return |(c & SHIFT_MASK);
   endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Decode-side and datapath-side handshake bundle of alu_ctrl_seq.
// master = instruction decode / datapath, slave = the sequencer.
interface alu_ctrl_seq_if
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
);
   localparam int SHW = $clog2(DATA_W);

   logic              in_valid;
   logic              in_ready;
   logic [3:0]        aluop;
   logic [3:0]        func;
   logic [SHW-1:0]    shamt;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] ctrl;
   logic              illegal;
   logic              shift_en;
   logic              busy;

   modport master (
      output in_valid, aluop, func, shamt, out_ready,
      input  in_ready, out_valid, ctrl, illegal,
      input  shift_en, busy
   );

   modport slave (
      input  in_valid, aluop, func, shamt, out_ready,
      output in_ready, out_valid, ctrl, illegal,
      output shift_en, busy
   );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational priority decoder: aluop/func to a one-hot
// control vector, or zero with illegal set.
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
(
   input  logic [3:0]        aluop,
   input  logic [3:0]        func,
   output logic [CTRL_W-1:0] ctrl,
   output logic              illegal
);

   logic lo_hit;
   logic a0_hit;

   // func 0..4 for either low class bit, 5..7 only for aluop[0] alone
   assign lo_hit = (|aluop[1:0]) && (func <= 4'd4);
   assign a0_hit = (aluop[1:0] == 2'b01) &&
                   (func >= 4'd5) && (func <= 4'd7);

   always_comb begin
      ctrl    = '0;
      illegal = 1'b0;
      priority case (1'b1)
         aluop[2]: ctrl[IDX_MEMADD] = 1'b1;
         aluop[3]: begin
            unique case (func)
               4'd0:    ctrl[IDX_COMPLESS] = 1'b1;
               4'd1:    ctrl[IDX_COMPEQ]   = 1'b1;
               4'd2:    ctrl[IDX_COMPNEQ]  = 1'b1;
               default: illegal = 1'b1;
            endcase
         end
         lo_hit || a0_hit: begin
            unique case (func)
               4'd0:    ctrl[IDX_ADD]  = 1'b1;
               4'd1:    ctrl[IDX_COMP] = 1'b1;
               4'd2:    ctrl[IDX_SLLV] = 1'b1;
               4'd3:    ctrl[IDX_SRLV] = 1'b1;
               4'd4:    ctrl[IDX_SRAV] = 1'b1;
               4'd5:    ctrl[IDX_AND]  = 1'b1;
               4'd6:    ctrl[IDX_XOR]  = 1'b1;
               4'd7:    ctrl[IDX_DIFF] = 1'b1;
               default: illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with valid/ready on both sides;
// sequences an iterative shifter for variable shifts.
module alu_ctrl_seq
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int SHIFT_STEP = 1
) (
   input logic           clk,
   input logic           rst_n,
   alu_ctrl_seq_if.slave bus
);

   localparam int SHW      = $clog2(DATA_W);
   localparam int LOG_STEP = $clog2(SHIFT_STEP);
   localparam logic [SHW:0] STEP_M1 = (SHW+1)'(SHIFT_STEP - 1);

   if (SHIFT_STEP < 1 || SHIFT_STEP > DATA_W ||
       (SHIFT_STEP & (SHIFT_STEP - 1)) != 0) begin : g_bad_step
      $error("SHIFT_STEP must be a power of 2 <= DATA_W");
   end

   state_e            state_q, state_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              illegal_q, illegal_d;
   logic [SHW-1:0]    count_q, count_d;

   logic [CTRL_W-1:0] dec_ctrl;
   logic              dec_illegal;
   logic [SHW:0]      round_up;
   logic [SHW-1:0]    nsteps;
   logic              in_ready;
   logic              accept;

   alu_ctrl_decode u_dec (
      .aluop   (bus.aluop),
      .func    (bus.func),
      .ctrl    (dec_ctrl),
      .illegal (dec_illegal)
   );

   // ceil(shamt / SHIFT_STEP), one spare bit for the carry
   assign round_up = {1'b0, bus.shamt} + STEP_M1;
   assign nsteps   = SHW'(round_up >> LOG_STEP);

   assign in_ready = (state_q == IDLE) ||
                     (state_q == DONE && bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      state_d   = state_q;
      ctrl_d    = ctrl_q;
      illegal_d = illegal_q;
      count_d   = count_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               ctrl_d    = dec_ctrl;
               illegal_d = dec_illegal;
               if (is_shift(dec_ctrl) && nsteps != '0) begin
                  state_d = SHIFT;
                  count_d = nsteps;
               end else begin
                  state_d = DONE;
                  count_d = '0;
               end
            end else if (state_q == DONE && bus.out_ready) begin
               state_d   = IDLE;
               ctrl_d    = '0;
               illegal_d = 1'b0;
            end
         end
         SHIFT: begin
            count_d = count_q - 1'b1;
            if (count_q == SHW'(1)) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ctrl_q    <= '0;
         illegal_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         illegal_q <= illegal_d;
         count_q   <= count_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == DONE);
   assign bus.shift_en  = (state_q == SHIFT);
   assign bus.busy      = (state_q != IDLE);
   assign bus.ctrl      = ctrl_q;
   assign bus.illegal   = illegal_q;

endmodule
